// File: rtl/avalon_gpio_pio_if.sv
// Avalon-MM slave bus bundle for avalon_gpio_pio: 3-bit word address,
// 32-bit data, active-low write strobe qualified by chipselect.
interface avalon_gpio_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_gpio_pio.sv
// avalon_gpio_pio: WIDTH-bit general-purpose I/O slave, zero wait states.
// Per-bit direction, atomic OUTSET/OUTCLEAR, SYNC_STAGES-deep input
// synchroniser. Define PIO_EDGE_CAPTURE_EN to build the IRQMASK/EDGECAP
// registers, the edge detector and irq; otherwise those addresses read 0
// and irq is tied low.
module avalon_gpio_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_gpio_pio_if.slave   avs,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   oe,
  output logic               irq
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_DIR      = 3'd1,
    REG_IRQMASK  = 3'd2,
    REG_EDGECAP  = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLEAR = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_addr_e;

  localparam logic [WIDTH-1:0] DATA_RESET = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  reg_addr_e        w_addr;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_rd;
  logic             w_unused;

  assign w_addr   = reg_addr_e'(avs.address);
  assign w_wr     = avs.chipselect & ~avs.write_n;
  assign w_wdata  = avs.writedata[WIDTH-1:0];
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_din    = (r_data_out & r_dir) | (w_sync & ~r_dir);
  // writedata bits at and above WIDTH are intentionally ignored
  assign w_unused = &{1'b0, avs.writedata};

  assign out_port = r_data_out;
  assign oe       = r_dir;

  // Input synchroniser chain; stage 0 samples the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Output data and direction registers, including atomic set/clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= DATA_RESET;
      r_dir      <= '0;
    end else if (w_wr) begin
      case (w_addr)
        REG_DATA:     r_data_out <= w_wdata;
        REG_DIR:      r_dir      <= w_wdata;
        REG_OUTSET:   r_data_out <= r_data_out | w_wdata;
        REG_OUTCLEAR: r_data_out <= r_data_out & ~w_wdata;
        default:      ;
      endcase
    end
  end

`ifdef PIO_EDGE_CAPTURE_EN
  logic [WIDTH-1:0]   r_hist;
  logic [WIDTH-1:0]   r_irqmask;
  logic [WIDTH-1:0]   r_edgecap;
  logic [SYNC_STAGES:0] r_valid;
  logic [WIDTH-1:0]   w_edges;
  logic [WIDTH-1:0]   w_clr;

  // History flop plus a fill marker: the edge detector stays disabled
  // until both the last sync stage and the history flop hold real
  // post-reset samples, so reset zeros never look like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist  <= '0;
      r_valid <= '0;
    end else begin
      r_hist  <= w_sync;
      r_valid <= {r_valid[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edge vector selected by EDGE_TYPE
  always_comb begin
    w_edges = '0;
    if (r_valid[SYNC_STAGES]) begin
      if (EDGE_TYPE == 0)      w_edges = w_sync & ~r_hist;
      else if (EDGE_TYPE == 1) w_edges = ~w_sync & r_hist;
      else                     w_edges = w_sync ^ r_hist;
    end
  end

  assign w_clr = (w_wr && (w_addr == REG_EDGECAP)) ? w_wdata : '0;

  // Interrupt mask and edge capture; a same-cycle edge beats the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_wr && (w_addr == REG_IRQMASK)) r_irqmask <= w_wdata;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edges;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);
`else
  assign irq = 1'b0;
`endif

  // Zero-latency read mux; unimplemented addresses and upper bits read 0
  always_comb begin
    w_rd = '0;
    case (w_addr)
      REG_DATA:    w_rd = w_din;
      REG_DIR:     w_rd = r_dir;
`ifdef PIO_EDGE_CAPTURE_EN
      REG_IRQMASK: w_rd = r_irqmask;
      REG_EDGECAP: w_rd = r_edgecap;
`endif
      default:     w_rd = '0;
    endcase
    avs.readdata = 32'(w_rd);
  end

endmodule

// File: doc/avalon_gpio_pio.md
# avalon_gpio_pio

Parametrised general-purpose I/O slave for the Qsys system: the successor to the fixed 3-bit output-only PIO. Provides WIDTH bidirectional bits with per-bit direction, atomic set/clear of output bits, a synchronised input path, and optional edge capture with a level interrupt to the Nios II. It sits on the Avalon-MM fabric as a zero-wait-state slave, next to the existing mode/select PIOs on the DE0-CV.

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- RESET_VALUE, 0: reset value of the output data register, truncated to WIDTH.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- EDGE_TYPE, 0: capture edge; 0 rising, 1 falling, 2 both.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, valid with chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; bits above WIDTH read 0.
- in_port  in  WIDTH  external inputs, asynchronous to clk.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable, equal to the direction register.
- irq  out  1  level interrupt, active high.

## Operation
- Register map, word addresses:
  - 0 DATA: write loads data_out. Read returns, per bit, data_out if direction=1, else the synchronised input.
  - 1 DIRECTION: 1 = output. Reads back.
  - 2 IRQMASK: per-bit interrupt enable. Reads back.
  - 3 EDGECAP: read returns captured edges. Writing 1 to a bit clears it. Writing 0 leaves it unchanged.
  - 4 OUTSET: write ORs writedata into data_out. Reads 0.
  - 5 OUTCLEAR: write clears data_out bits where writedata=1. Reads 0.
  - 6, 7: writes ignored; reads 0.
- A write occurs when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used.
- Input path: SYNC_STAGES flops on in_port, plus one history flop. The edge vector is derived from the last synchroniser stage versus the history flop, per EDGE_TYPE.
- A detected edge on bit i sets edgecap[i]. This happens regardless of direction and mask.
- If an edge and a write-1-to-clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq = |(edgecap & irqmask), driven from registers.
- Reset values: data_out=RESET_VALUE, direction=0 (all inputs), irqmask=0, edgecap=0, sync/history flops=0. Consequently out_port=RESET_VALUE, oe=0 and irq=0.
- Reset asserted mid-operation clears all state immediately and asynchronously. Edges are not detected from the reset-derived history flop values; the first detectable edge is the first genuine input transition after reset release.

## Timing
- Writes take effect on the clk edge where the write is sampled. out_port, oe, irqmask and edgecap are updated in the next cycle.
- Reads have zero wait states and zero read latency: readdata is valid in the same cycle as address. No side effects on read.
- Input latency: an in_port change appears in a DATA read SYNC_STAGES cycles later.
- Edge-to-edgecap latency: SYNC_STAGES+1 cycles. irq follows edgecap in the same cycle, being combinational from registers.
- Unmasking an already-captured bit raises irq in the cycle after the IRQMASK write.
- Input pulses shorter than one clk period may be missed. This is documented, not guarded.

## Configuration
- PIO_EDGE_CAPTURE_EN defined: IRQMASK and EDGECAP registers, edge detector and irq are present as described.
- PIO_EDGE_CAPTURE_EN undefined:
  - Addresses 2 and 3 behave as reserved: writes ignored, reads 0.
  - irq is tied to 0.
  - The history flop and edge logic are removed.
  - The DATA/DIRECTION/OUTSET/OUTCLEAR behaviour is unchanged.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, oe=0, irq=0; read addr 0 with in_port=8'h3C, after 2 cycles -> 32'h0000003C.
- Write DIRECTION=8'h0F, DATA=8'h12, then OUTSET=8'h80, then OUTCLEAR=8'h02; in_port=8'hF0 -> out_port=8'h90, and a DATA read returns 8'hF0 for input bits merged with 8'h00 for output bits, i.e. 8'hF0.
- EDGE_TYPE=0, IRQMASK=8'h01, rising edge on in_port[0] -> edgecap=8'h01 exactly 3 cycles later, irq=1 in the same cycle; write EDGECAP=8'h01 -> irq=0 next cycle.
- Rising edge on bit 3 arrives in the same cycle as a write EDGECAP=8'h08 -> edgecap[3] remains 1.
- Capture on bit 5 with IRQMASK=0 -> irq=0; write IRQMASK=8'h20 -> irq=1 the next cycle. Pulse reset_n low -> irq=0 and edgecap=0 asynchronously.
- Build without PIO_EDGE_CAPTURE_EN: toggle in_port and write addr 2 = 32'hFFFFFFFF -> irq stays 0, and reads of addr 2 and addr 3 return 0.
